if_fetch_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC register that drives

---
 rtl/if_fetch_stage_pkg.sv | 30 +++
 rtl/if_fetch_stage_if_id_reg.sv | 52 +++++
 rtl/if_fetch_stage.sv | 144 ++++++++++++++
 tb/tb_if_fetch_stage.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/if_fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_stage_pkg
//   Shared constants and helpers for the instruction-fetch stage and its
//   IF/ID pipeline register.
//   - DEFAULT_RESET_PC : PC value loaded on reset (default parameter value)
//   - NOP_INSTR_WORD   : sll $0,$0,0, injected into IF/ID as a bubble
//   - ST_BOOT / ST_RUN : fetch FSM state encodings
//   - PC_INC           : constant operand fed to the external PC adder
//   - align_pc / is_misaligned : word-alignment helpers for redirect targets
// -----------------------------------------------------------------------------
package if_fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_WORD   = 32'h0000_0000;
    localparam logic [31:0] PC_INC           = 32'd4;

    localparam logic [0:0]  ST_BOOT = 1'b0;
    localparam logic [0:0]  ST_RUN  = 1'b1;

    // Clear the byte-offset bits so the PC always points at a word.
    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

    // True when an address is not word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
//   IF/ID pipeline register with hold and flush. Priority: reset > flush >
//   hold > load. A flush injects NOP_INSTR with valid cleared; a hold keeps
//   every field exactly as it is. The same shape is reused for later stages.
//   Ports:
//     clk, reset          clock, synchronous active-high reset
//     hold                keep current contents
//     flush               replace contents with a bubble
//     instr_in, pc_plus4_in, valid_in   next contents
//     instr, pc_plus4, valid            registered contents
// -----------------------------------------------------------------------------
module if_id_reg
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hold,
    input  logic        flush,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_plus4_in,
    input  logic        valid_in,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // Pipeline register update: flush wins over hold so a squashed
    // wrong-path instruction never survives a stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= 32'h0000_0000;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= pc_plus4;
            valid    <= 1'b0;
        end else if (hold) begin
            instr    <= instr;
            pc_plus4 <= pc_plus4;
            valid    <= valid;
        end else begin
            instr    <= instr_in;
            pc_plus4 <= pc_plus4_in;
            valid    <= valid_in;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// -----------------------------------------------------------------------------
// if_fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Holds the PC,
//   selects the next PC (jump > branch > stall hold > PC+4) and captures the
//   IF/ID register consumed by decode.
//   Optional feature macro: PC_ALIGN_CHECK_EN
//     defined   : misaligned redirect targets are word-aligned and set the
//                 sticky misalign_err flag
//     undefined : targets are loaded unmodified, misalign_err tied low
//   Ports:
//     clk, reset                      clock, synchronous active-high reset
//     stall, flush                    hazard-unit controls
//     branch_taken, branch_target     ID-resolved branch redirect
//     jump, jump_target               j/jal redirect
//     pc_plus4_in                     external adder result (pc_out + pc_inc)
//     imem_instr                      instruction read at pc_out
//     pc_out, pc_inc                  imem address / adder operands
//     ifid_instr, ifid_pc_plus4, ifid_valid   IF/ID register
//     misalign_err                    sticky misaligned-redirect flag
// -----------------------------------------------------------------------------
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] pc_plus4_in,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc_out,
    output logic [31:0] pc_inc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misalign_err
);

    logic [31:0] pc_r;
    logic [0:0]  state_r;
    logic        redirect_s;
    logic [31:0] target_s;
    logic [31:0] target_load_s;
    logic [31:0] next_pc_s;
    logic        flush_ifid_s;
    logic        ifid_valid_s;

    assign redirect_s   = jump | branch_taken;
    // A redirect always leaves one bubble behind it in IF/ID.
    assign flush_ifid_s = redirect_s | flush;

    // Redirect target select: jump beats branch when both fire.
    always_comb begin
        target_s = branch_target;
        if (jump) begin
            target_s = jump_target;
        end else begin
            target_s = branch_target;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_r;

    assign target_load_s = align_pc(target_s);

    // Sticky misaligned-redirect flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_r <= 1'b0;
        end else if (redirect_s && is_misaligned(target_s)) begin
            misalign_r <= 1'b1;
        end else begin
            misalign_r <= misalign_r;
        end
    end

    assign misalign_err = misalign_r;
`else
    assign target_load_s = target_s;
    assign misalign_err  = 1'b0;
`endif

    // Next-PC select: a redirect loads even while stalled.
    always_comb begin
        next_pc_s = pc_plus4_in;
        if (redirect_s) begin
            next_pc_s = target_load_s;
        end else if (stall) begin
            next_pc_s = pc_r;
        end else begin
            next_pc_s = pc_plus4_in;
        end
    end

    // PC register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    // Fetch FSM: one BOOT cycle after reset, then RUN until the next reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_BOOT;
        end else begin
            case (state_r)
                ST_BOOT: state_r <= ST_RUN;
                ST_RUN:  state_r <= ST_RUN;
                default: state_r <= ST_BOOT;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clk         (clk),
        .reset       (reset),
        .hold        (stall),
        .flush       (flush_ifid_s),
        .instr_in    (imem_instr),
        .pc_plus4_in (pc_plus4_in),
        .valid_in    (1'b1),
        .instr       (ifid_instr),
        .pc_plus4    (ifid_pc_plus4),
        .valid       (ifid_valid_s)
    );

    assign pc_out     = pc_r;
    assign pc_inc     = PC_INC;
    // Nothing decoded is real until the boot cycle has passed.
    assign ifid_valid = ifid_valid_s & (state_r == ST_RUN);

endmodule

// File: tb/tb_if_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_if_fetch_stage
//   Directed bench for if_fetch_stage. The bench plays the PC adder
//   (pc_plus4_in = pc_out + pc_inc) and an instruction memory that returns
//   the fetch address as the instruction word, so captured IF/ID contents are
//   easy to predict by hand.
// -----------------------------------------------------------------------------
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] pc_plus4_in;
    logic [31:0] imem_instr;
    logic [31:0] pc_out;
    logic [31:0] pc_inc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    if_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .pc_plus4_in   (pc_plus4_in),
        .imem_instr    (imem_instr),
        .pc_out        (pc_out),
        .pc_inc        (pc_inc),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus4 (ifid_pc_plus4),
        .ifid_valid    (ifid_valid),
        .misalign_err  (misalign_err)
    );

    always #5 clk = ~clk;

    assign pc_plus4_in = pc_out + pc_inc;
    assign imem_instr  = pc_out;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [31:0] e_pc,
                               input logic [31:0] e_instr, input logic [31:0] e_pc4,
                               input logic e_valid);
        check({tag, ".pc"},    pc_out,            e_pc);
        check({tag, ".instr"}, ifid_instr,        e_instr);
        check({tag, ".pc4"},   ifid_pc_plus4,     e_pc4);
        check({tag, ".valid"}, {31'd0, ifid_valid}, {31'd0, e_valid});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;

        // 1. reset for two cycles, then run sequentially
        step(); step();
        check_state("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check("reset.misalign", {31'd0, misalign_err}, 32'h0);
        check("pc_inc", pc_inc, 32'd4);
        reset = 1'b0;
        #1;
        check_state("boot", 32'h0, 32'h0, 32'h0, 1'b0);
        step(); check_state("seq1", 32'h4, 32'h0, 32'h4, 1'b1);
        step(); check_state("seq2", 32'h8, 32'h4, 32'h8, 1'b1);
        step(); check_state("seq3", 32'hC, 32'h8, 32'hC, 1'b1);
        step(); check_state("seq4", 32'h10, 32'hC, 32'h10, 1'b1);

        // 2. stall three cycles at 0x10
        stall = 1'b1;
        step(); check_state("stall1", 32'h10, 32'hC, 32'h10, 1'b1);
        step(); check_state("stall2", 32'h10, 32'hC, 32'h10, 1'b1);
        step(); check_state("stall3", 32'h10, 32'hC, 32'h10, 1'b1);
        stall = 1'b0;
        step(); check_state("resume", 32'h14, 32'h10, 32'h14, 1'b1);

        // 3. taken branch while stalled
        branch_taken = 1'b1; branch_target = 32'h40; stall = 1'b1;
        step(); check_state("br_stall", 32'h40, 32'h0, 32'h14, 1'b0);
        branch_taken = 1'b0; stall = 1'b0;
        step(); check_state("br_fetch", 32'h44, 32'h40, 32'h44, 1'b1);

        // 4. jump and branch together: jump wins
        jump = 1'b1; jump_target = 32'h100; branch_taken = 1'b1; branch_target = 32'h40;
        step(); check_state("jmp_br", 32'h100, 32'h0, 32'h44, 1'b0);
        jump = 1'b0; branch_taken = 1'b0;
        step(); check_state("jmp_fetch", 32'h104, 32'h100, 32'h104, 1'b1);

        // 5. flush alone at 0x20, then flush with stall
        jump = 1'b1; jump_target = 32'h20;
        step(); check("to20.pc", pc_out, 32'h20);
        jump = 1'b0; flush = 1'b1;
        step(); check_state("flush", 32'h24, 32'h0, 32'h104, 1'b0);
        flush = 1'b0;
        step(); check_state("post_flush", 32'h28, 32'h24, 32'h28, 1'b1);
        flush = 1'b1; stall = 1'b1;
        step(); check_state("flush_stall", 32'h28, 32'h0, 32'h28, 1'b0);
        flush = 1'b0; stall = 1'b0;
        step(); check_state("after_fs", 32'h2C, 32'h28, 32'h2C, 1'b1);

        // reset mid-run returns to BOOT
        reset = 1'b1;
        step(); check_state("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
        reset = 1'b0;
        step(); check_state("reboot", 32'h4, 32'h0, 32'h4, 1'b1);

        // wrap from the top of the address space
        jump = 1'b1; jump_target = 32'hFFFF_FFFC;
        step(); check("wrap_top.pc", pc_out, 32'hFFFF_FFFC);
        jump = 1'b0;
        step(); check_state("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 1'b1);

        // 6. misaligned jump target
        jump = 1'b1; jump_target = 32'h103;
        step();
`ifdef PC_ALIGN_CHECK_EN
        check("mis.pc", pc_out, 32'h100);
        check("mis.err", {31'd0, misalign_err}, 32'h1);
        jump = 1'b0;
        step();
        check("mis_hold.pc", pc_out, 32'h104);
        check("mis_hold.err", {31'd0, misalign_err}, 32'h1);
`else
        check("mis.pc", pc_out, 32'h103);
        check("mis.err", {31'd0, misalign_err}, 32'h0);
        jump = 1'b0;
        step();
        check("mis_hold.pc", pc_out, 32'h107);
        check("mis_hold.err", {31'd0, misalign_err}, 32'h0);
`endif
        check("mis.valid", {31'd0, ifid_valid}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
